// File: rtl/sprite_scheduler.sv
// Scanline sprite scheduler: scans the attribute table for a requested line and hands hits to the drawer one at a time.
// Optional per-line draw cap enabled by defining SPRITE_LINE_LIMIT_EN.
module sprite_scheduler #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           line_start,
  input  logic [9:0]                     line_num,
  input  logic                           attr_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
  input  logic [31:0]                    attr_wdata,
  output logic                           draw_start,
  output logic [4:0]                     row_in_sprite,
  output logic [9:0]                     sprite_column,
  output logic [4:0]                     img_num,
  input  logic                           draw_finish,
  output logic                           busy,
  output logic                           line_done,
  output logic [5:0]                     sprites_drawn,
  output logic                           overflow
);

  localparam int AW = $clog2(NUM_SPRITES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {IDLE, CHECK, START, SETTLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic       en;
    logic [4:0] img;
    logic [9:0] x;
    logic [9:0] y;
  } attr_t;

  attr_t         attr [NUM_SPRITES];
  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [9:0]    line_q;
  attr_t         cur;
  logic [10:0]   diff;
  logic          hit, cap, issue, last;
  logic          unused_bits;

  assign unused_bits = ^{attr_wdata[30:25], 6'(MAX_PER_LINE)};

  // NOTE: the table is a register file with reset because reset must disable every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= '0;
    end else if (attr_we) begin
      attr[attr_addr] <= {attr_wdata[31], attr_wdata[24:0]};
    end
  end

  // The scan compares in 11 bits so a sprite below the line never wraps into a hit.
  assign cur   = attr[idx];
  assign diff  = {1'b0, line_q} - {1'b0, cur.y};
  assign hit   = cur.en && (line_q >= cur.y) && (diff < 11'd32);
  assign last  = (idx == LAST_IDX);
`ifdef SPRITE_LINE_LIMIT_EN
  assign cap   = (sprites_drawn == 6'(MAX_PER_LINE));
`else
  assign cap   = 1'b0;
`endif
  assign issue = (state == CHECK) && hit && !cap;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start) state_nxt = CHECK;
      CHECK: begin
        if (hit)       state_nxt = cap ? DONE : START;
        else if (last) state_nxt = DONE;
      end
      START:   state_nxt = SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT:    if (draw_finish) state_nxt = last ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    draw_start = (state == START);
    busy       = (state != IDLE);
    line_done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx           <= '0;
      line_q        <= '0;
      sprites_drawn <= '0;
      row_in_sprite <= '0;
      sprite_column <= '0;
      img_num       <= '0;
    end else begin
      case (state)
        IDLE: if (line_start) begin
          line_q        <= line_num;
          idx           <= '0;
          sprites_drawn <= '0;
        end
        CHECK: begin
          if (issue) begin
            row_in_sprite <= diff[4:0];
            sprite_column <= cur.x;
            img_num       <= cur.img;
          end else if (!hit && !last) begin
            idx <= idx + 1'b1;
          end
        end
        START: sprites_drawn <= sprites_drawn + 6'd1;
        WAIT:  if (draw_finish && !last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SPRITE_LINE_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!reset)                                  overflow <= 1'b0;
    else if (state == IDLE && line_start)        overflow <= 1'b0;
    else if (state == CHECK && hit && cap)       overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
